// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-peripheral request/response bus
// between port 0 (instruction fetch) and port 1 (load/store).
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; otherwise port 0 has fixed priority.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 2'd1
`endif
`ifndef MEM_COUNT_HALF
`define MEM_COUNT_HALF 2'd2
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_MISALIGNED
`define MEM_CODE_MISALIGNED 3'd1
`endif
`ifndef MEM_CODE_OUT_OF_BOUNDS
`define MEM_CODE_OUT_OF_BOUNDS 3'd2
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd3
`endif
`ifndef MEM_CODE_READ
`define MEM_CODE_READ 3'd4
`endif
`ifndef MEM_CODE_WRITE
`define MEM_CODE_WRITE 3'd5
`endif

module mem_port_arbiter #(
    parameter int unsigned RESP_LATENCY = 1,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    i_req0_valid,
    input  logic [`ADDR_W-1:0]      i_req0_addr,
    input  logic [`WORD_W-1:0]      i_req0_wr_data,
    input  logic                    i_req0_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_req0_count,
    output logic                    o_req0_ready,
    input  logic                    i_req1_valid,
    input  logic [`ADDR_W-1:0]      i_req1_addr,
    input  logic [`WORD_W-1:0]      i_req1_wr_data,
    input  logic                    i_req1_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_req1_count,
    output logic                    o_req1_ready,
    output logic [1:0]              o_rsp_valid,
    output logic [`WORD_W-1:0]      o_rsp_rd_data,
    output logic [`MEM_CODE_W-1:0]  o_rsp_code,
    output logic [`ADDR_W-1:0]      o_mem_req_addr,
    output logic [`WORD_W-1:0]      o_mem_req_wr_data,
    output logic                    o_mem_req_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_mem_req_count,
    input  logic [`WORD_W-1:0]      i_mem_res_rd_data,
    input  logic [`MEM_CODE_W-1:0]  i_mem_res_code,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [CNT_W-1:0]        r_cnt;
    logic [`ADDR_W-1:0]      r_addr;
    logic [`WORD_W-1:0]      r_wr_data;
    logic                    r_wr_en;
    logic [`MEM_COUNT_W-1:0] r_count;
    logic                    r_gnt;
    logic [1:0]              r_rsp_valid;
    logic [`WORD_W-1:0]      r_rsp_rd_data;
    logic [`MEM_CODE_W-1:0]  r_rsp_code;

    logic                    w_elig0;
    logic                    w_elig1;
    logic                    w_pick1;
    logic                    w_rdy0;
    logic                    w_rdy1;
    logic                    w_accept;
    logic                    w_cnt_zero;

    assign w_elig0    = i_req0_valid && (i_req0_count != `MEM_COUNT_NONE);
    assign w_elig1    = i_req1_valid && (i_req1_count != `MEM_COUNT_NONE);
    assign w_cnt_zero = (r_cnt == '0);

    // r_gnt holds the most recently accepted port, so it doubles as the
    // last-grant register for round-robin.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign w_pick1 = w_elig1 && (!w_elig0 || !r_gnt);
`else
    assign w_pick1 = w_elig1 && !w_elig0;
`endif

    assign w_rdy0   = (r_state == ST_IDLE) && w_elig0 && !w_pick1;
    assign w_rdy1   = (r_state == ST_IDLE) && w_pick1;
    assign w_accept = w_rdy0 || w_rdy1;

    assign o_req0_ready = w_rdy0;
    assign o_req1_ready = w_rdy1;
    assign o_busy       = (r_state != ST_IDLE);

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rd_data = r_rsp_rd_data;
    assign o_rsp_code    = r_rsp_code;

    // Peripheral bus carries the latched request only during ISSUE.
    always_comb begin
        o_mem_req_addr    = '0;
        o_mem_req_wr_data = '0;
        o_mem_req_wr_en   = 1'b0;
        o_mem_req_count   = `MEM_COUNT_NONE;
        if (r_state == ST_ISSUE) begin
            o_mem_req_addr    = r_addr;
            o_mem_req_wr_data = r_wr_data;
            o_mem_req_wr_en   = r_wr_en;
            o_mem_req_count   = r_count;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_cnt_zero) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and response capture.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_wr_en       <= 1'b0;
            r_count       <= `MEM_COUNT_NONE;
            r_gnt         <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_rd_data <= '0;
            r_rsp_code    <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= w_pick1 ? i_req1_addr    : i_req0_addr;
                        r_wr_data <= w_pick1 ? i_req1_wr_data : i_req0_wr_data;
                        r_wr_en   <= w_pick1 ? i_req1_wr_en   : i_req0_wr_en;
                        r_count   <= w_pick1 ? i_req1_count   : i_req0_count;
                        r_gnt     <= w_pick1;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= CNT_W'(RESP_LATENCY - 32'd1);
                end
                ST_WAIT: begin
                    if (w_cnt_zero) begin
                        r_rsp_rd_data <= i_mem_res_rd_data;
                        r_rsp_code    <= i_mem_res_code;
                        r_rsp_valid   <= r_gnt ? 2'b10 : 2'b01;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A uses RESP_LATENCY=1,
// instance B uses RESP_LATENCY=3 and is held in reset until its test.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 2'd1
`endif
`ifndef MEM_COUNT_HALF
`define MEM_COUNT_HALF 2'd2
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_MISALIGNED
`define MEM_CODE_MISALIGNED 3'd1
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd3
`endif
`ifndef MEM_CODE_READ
`define MEM_CODE_READ 3'd4
`endif
`ifndef MEM_CODE_WRITE
`define MEM_CODE_WRITE 3'd5
`endif

module tb_mem_port_arbiter;

    logic                    clk;
    logic                    aresetn;
    logic                    aresetn_b;
    logic                    req0_valid;
    logic [`ADDR_W-1:0]      req0_addr;
    logic [`WORD_W-1:0]      req0_wr_data;
    logic                    req0_wr_en;
    logic [`MEM_COUNT_W-1:0] req0_count;
    logic                    req1_valid;
    logic [`ADDR_W-1:0]      req1_addr;
    logic [`WORD_W-1:0]      req1_wr_data;
    logic                    req1_wr_en;
    logic [`MEM_COUNT_W-1:0] req1_count;
    logic [`WORD_W-1:0]      mem_rd_data;
    logic [`MEM_CODE_W-1:0]  mem_code;

    logic                    a_rdy0, a_rdy1, a_wr_en, a_busy;
    logic [1:0]              a_rsp_valid;
    logic [`WORD_W-1:0]      a_rsp_data, a_wr_data;
    logic [`MEM_CODE_W-1:0]  a_rsp_code;
    logic [`ADDR_W-1:0]      a_addr;
    logic [`MEM_COUNT_W-1:0] a_count;

    logic                    b_rdy0, b_rdy1, b_wr_en, b_busy;
    logic [1:0]              b_rsp_valid;
    logic [`WORD_W-1:0]      b_rsp_data, b_wr_data;
    logic [`MEM_CODE_W-1:0]  b_rsp_code;
    logic [`ADDR_W-1:0]      b_addr;
    logic [`MEM_COUNT_W-1:0] b_count;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.RESP_LATENCY(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .aresetn(aresetn),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_wr_data(req0_wr_data),
        .i_req0_wr_en(req0_wr_en), .i_req0_count(req0_count), .o_req0_ready(a_rdy0),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_wr_data(req1_wr_data),
        .i_req1_wr_en(req1_wr_en), .i_req1_count(req1_count), .o_req1_ready(a_rdy1),
        .o_rsp_valid(a_rsp_valid), .o_rsp_rd_data(a_rsp_data), .o_rsp_code(a_rsp_code),
        .o_mem_req_addr(a_addr), .o_mem_req_wr_data(a_wr_data), .o_mem_req_wr_en(a_wr_en),
        .o_mem_req_count(a_count), .i_mem_res_rd_data(mem_rd_data), .i_mem_res_code(mem_code),
        .o_busy(a_busy)
    );

    mem_port_arbiter #(.RESP_LATENCY(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .aresetn(aresetn_b),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_wr_data(req0_wr_data),
        .i_req0_wr_en(req0_wr_en), .i_req0_count(req0_count), .o_req0_ready(b_rdy0),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_wr_data(req1_wr_data),
        .i_req1_wr_en(req1_wr_en), .i_req1_count(req1_count), .o_req1_ready(b_rdy1),
        .o_rsp_valid(b_rsp_valid), .o_rsp_rd_data(b_rsp_data), .o_rsp_code(b_rsp_code),
        .o_mem_req_addr(b_addr), .o_mem_req_wr_data(b_wr_data), .o_mem_req_wr_en(b_wr_en),
        .o_mem_req_count(b_count), .i_mem_res_rd_data(mem_rd_data), .i_mem_res_code(mem_code),
        .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_gnt;
        aresetn      = 1'b0;
        aresetn_b    = 1'b0;
        req0_valid   = 1'b0; req0_addr = '0; req0_wr_data = '0; req0_wr_en = 1'b0;
        req0_count   = `MEM_COUNT_NONE;
        req1_valid   = 1'b0; req1_addr = '0; req1_wr_data = '0; req1_wr_en = 1'b0;
        req1_count   = `MEM_COUNT_NONE;
        mem_rd_data  = '0;
        mem_code     = '0;
        tick(); tick();

        // Reset state
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_data",  a_rsp_data, 32'd0);
        chk("rst_rsp_code",  32'(a_rsp_code), 32'd0);
        chk("rst_mem_count", 32'(a_count), 32'(`MEM_COUNT_NONE));
        chk("rst_mem_addr",  a_addr, 32'd0);
        chk("rst_busy",      32'(a_busy), 32'd0);
        aresetn = 1'b1;
        tick();

        // Single read on port 0
        req0_valid = 1'b1; req0_addr = 32'h4; req0_count = `MEM_COUNT_WORD; req0_wr_en = 1'b0;
        mem_rd_data = 32'hDEADBEEF; mem_code = `MEM_CODE_READ;
        #1;
        chk("rd_ready0", 32'(a_rdy0), 32'd1);
        chk("rd_ready1", 32'(a_rdy1), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("rd_issue_count", 32'(a_count), 32'(`MEM_COUNT_WORD));
        chk("rd_issue_addr",  a_addr, 32'h4);
        chk("rd_issue_busy",  32'(a_busy), 32'd1);
        chk("rd_issue_rsp",   32'(a_rsp_valid), 32'd0);
        tick();
        chk("rd_wait_count",  32'(a_count), 32'(`MEM_COUNT_NONE));
        chk("rd_wait_rsp",    32'(a_rsp_valid), 32'd0);
        tick();
        chk("rd_rsp_valid",   32'(a_rsp_valid), 32'h1);
        chk("rd_rsp_data",    a_rsp_data, 32'hDEADBEEF);
        chk("rd_rsp_code",    32'(a_rsp_code), 32'(`MEM_CODE_READ));
        chk("rd_idle_busy",   32'(a_busy), 32'd0);
        tick();
        chk("rd_pulse_end",   32'(a_rsp_valid), 32'd0);
        chk("rd_data_hold",   a_rsp_data, 32'hDEADBEEF);

        // Simultaneous requests: port 0 read, port 1 byte write
        req0_valid = 1'b1; req0_addr = 32'h8; req0_count = `MEM_COUNT_WORD; req0_wr_en = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h9; req1_count = `MEM_COUNT_BYTE; req1_wr_en = 1'b1;
        req1_wr_data = 32'hA5;
        mem_rd_data = 32'h11112222; mem_code = `MEM_CODE_READ;
        #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Last grant was port 0, so port 1 goes first here.
        chk("sim_ready0", 32'(a_rdy0), 32'd0);
        chk("sim_ready1", 32'(a_rdy1), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("sim_issue1_addr", a_addr, 32'h9);
        mem_rd_data = 32'h0; mem_code = `MEM_CODE_WRITE;
        tick(); tick();
        chk("sim_rsp1_valid", 32'(a_rsp_valid), 32'h2);
        chk("sim_rsp1_code",  32'(a_rsp_code), 32'(`MEM_CODE_WRITE));
        chk("sim_ready0_b",   32'(a_rdy0), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("sim_issue0_addr", a_addr, 32'h8);
        mem_rd_data = 32'h11112222; mem_code = `MEM_CODE_READ;
        tick(); tick();
        chk("sim_rsp0_valid", 32'(a_rsp_valid), 32'h1);
        chk("sim_rsp0_data",  a_rsp_data, 32'h11112222);
        exp_gnt = 1'b0;
`else
        chk("sim_ready0", 32'(a_rdy0), 32'd1);
        chk("sim_ready1", 32'(a_rdy1), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("sim_issue0_addr",  a_addr, 32'h8);
        chk("sim_issue0_count", 32'(a_count), 32'(`MEM_COUNT_WORD));
        tick(); tick();
        chk("sim_rsp0_valid", 32'(a_rsp_valid), 32'h1);
        chk("sim_rsp0_data",  a_rsp_data, 32'h11112222);
        chk("sim_ready1_b",   32'(a_rdy1), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("sim_issue1_addr",  a_addr, 32'h9);
        chk("sim_issue1_wdata", a_wr_data, 32'hA5);
        chk("sim_issue1_wren",  32'(a_wr_en), 32'd1);
        chk("sim_issue1_count", 32'(a_count), 32'(`MEM_COUNT_BYTE));
        mem_rd_data = 32'h0; mem_code = `MEM_CODE_WRITE;
        tick(); tick();
        chk("sim_rsp1_valid", 32'(a_rsp_valid), 32'h2);
        chk("sim_rsp1_code",  32'(a_rsp_code), 32'(`MEM_CODE_WRITE));
        exp_gnt = 1'b1;
`endif

        // Continuous contention for 12 transactions
        req0_valid = 1'b1; req0_addr = 32'h40; req0_count = `MEM_COUNT_WORD; req0_wr_en = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h80; req1_count = `MEM_COUNT_WORD; req1_wr_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_gnt = ~exp_gnt;
`else
            exp_gnt = 1'b0;
`endif
            #1;
            chk($sformatf("cont_ready0_%0d", k), 32'(a_rdy0), 32'(!exp_gnt));
            chk($sformatf("cont_ready1_%0d", k), 32'(a_rdy1), 32'(exp_gnt));
            tick(); tick(); tick();
            chk($sformatf("cont_rsp_%0d", k), 32'(a_rsp_valid), exp_gnt ? 32'h2 : 32'h1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Count NONE is never eligible
        req0_valid = 1'b1; req0_count = `MEM_COUNT_NONE;
        #1;
        chk("none_ready0", 32'(a_rdy0), 32'd0);
        tick();
        chk("none_busy", 32'(a_busy), 32'd0);

        // Error forwarding: port 1 misaligned half-word, port 0 ineligible
        req1_valid = 1'b1; req1_addr = 32'h3; req1_count = `MEM_COUNT_HALF; req1_wr_en = 1'b0;
        mem_rd_data = 32'h0; mem_code = `MEM_CODE_MISALIGNED;
        #1;
        chk("err_ready0", 32'(a_rdy0), 32'd0);
        chk("err_ready1", 32'(a_rdy1), 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("err_issue_count", 32'(a_count), 32'(`MEM_COUNT_HALF));
        chk("err_issue_addr",  a_addr, 32'h3);
        tick(); tick();
        chk("err_rsp_valid", 32'(a_rsp_valid), 32'h2);
        chk("err_rsp_code",  32'(a_rsp_code), 32'(`MEM_CODE_MISALIGNED));
        chk("err_rsp_data",  a_rsp_data, 32'h0);
        tick();

        // Reset during WAIT
        req1_valid = 1'b1; req1_addr = 32'h20; req1_count = `MEM_COUNT_WORD;
        mem_rd_data = 32'h77778888; mem_code = `MEM_CODE_READ;
        tick();
        req1_valid = 1'b0;
        tick();
        chk("rmid_in_wait", 32'(a_busy), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("rmid_busy",      32'(a_busy), 32'd0);
        chk("rmid_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rmid_rsp_data",  a_rsp_data, 32'd0);
        chk("rmid_rsp_code",  32'(a_rsp_code), 32'd0);
        chk("rmid_count",     32'(a_count), 32'(`MEM_COUNT_NONE));
        tick();
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rmid_no_pulse_%0d", k), 32'(a_rsp_valid), 32'd0);
        end
        req1_valid = 1'b1; req1_addr = 32'h24; req1_count = `MEM_COUNT_WORD;
        mem_rd_data = 32'hCAFEF00D; mem_code = `MEM_CODE_READ;
        #1;
        chk("rpost_ready1", 32'(a_rdy1), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick(); tick();
        chk("rpost_rsp_valid", 32'(a_rsp_valid), 32'h2);
        chk("rpost_rsp_data",  a_rsp_data, 32'hCAFEF00D);

        // RESP_LATENCY=3 on instance B
        aresetn_b = 1'b1;
        tick();
        req0_valid = 1'b1; req0_addr = 32'h10; req0_count = `MEM_COUNT_WORD; req0_wr_en = 1'b0;
        mem_rd_data = 32'hBAD0BAD0; mem_code = `MEM_CODE_INVALID;
        #1;
        chk("lat_ready0", 32'(b_rdy0), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("lat_issue_count", 32'(b_count), 32'(`MEM_COUNT_WORD));
        chk("lat_busy_0", 32'(b_busy), 32'd1);
        chk("lat_rsp_0",  32'(b_rsp_valid), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            if (k == 3) begin
                mem_rd_data = 32'h5A5A1234; mem_code = `MEM_CODE_READ;
            end
            chk($sformatf("lat_busy_%0d", k), 32'(b_busy), 32'd1);
            chk($sformatf("lat_rsp_%0d", k),  32'(b_rsp_valid), 32'd0);
        end
        tick();
        chk("lat_rsp_valid", 32'(b_rsp_valid), 32'h1);
        chk("lat_rsp_data",  b_rsp_data, 32'h5A5A1234);
        chk("lat_rsp_code",  32'(b_rsp_code), 32'(`MEM_CODE_READ));
        chk("lat_idle_busy", 32'(b_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
